// File: rtl/counter_modulo_down_if.sv
// Control/status bundle for counter_modulo_down.
// Define COUNTER_UPDOWN_EN to add the 'up' direction input.
interface counter_modulo_down_if #(
    parameter int WIDTH = 3
);
    logic             ce;
    logic             load;
    logic [WIDTH-1:0] din;
    logic             mode;
`ifdef COUNTER_UPDOWN_EN
    logic             up;
`endif
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             done;

`ifdef COUNTER_UPDOWN_EN
    modport master (output ce, load, din, mode, up, input out, tc, done);
    modport slave  (input ce, load, din, mode, up, output out, tc, done);
`else
    modport master (output ce, load, din, mode, input out, tc, done);
    modport slave  (input ce, load, din, mode, output out, tc, done);
`endif
endinterface

// File: rtl/counter_modulo_down.sv
// Loadable modulo-N down-counter with borrow strobe, wrap and one-shot modes.
// Optional COUNTER_UPDOWN_EN adds an 'up' input for up-counting.
module counter_modulo_down #(
    parameter int MODULO = 7,
    parameter int WIDTH  = $clog2(MODULO)
) (
    input  logic                  clk,
    input  logic                  rst,
    counter_modulo_down_if.slave  bus
);
    typedef enum logic {RUN, HALT} state_t;

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);

    state_t           state_q;
    logic [WIDTH-1:0] out_q;
    logic             done_q;

    logic             count_up;
    logic             at_end;
    logic [WIDTH-1:0] step_d;
    logic [WIDTH-1:0] wrap_d;
    logic [WIDTH-1:0] load_d;

`ifdef COUNTER_UPDOWN_EN
    assign count_up = bus.up;
`else
    assign count_up = 1'b0;
`endif

    // The terminal value depends on direction: 0 going down, MAX going up.
    always_comb begin
        at_end = count_up ? (out_q == MAX) : (out_q == '0);
        step_d = count_up ? out_q + 1'b1 : out_q - 1'b1;
        wrap_d = count_up ? '0 : MAX;
        load_d = (bus.din > MAX) ? MAX : bus.din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            out_q   <= MAX;
            done_q  <= 1'b0;
        end else if (bus.load) begin
            state_q <= RUN;
            out_q   <= load_d;
            done_q  <= 1'b0;
        end else if (bus.ce && state_q == RUN) begin
            if (!at_end) begin
                out_q <= step_d;
            end else if (bus.mode) begin
                // One-shot: park on the terminal value until reloaded.
                state_q <= HALT;
                done_q  <= 1'b1;
            end else begin
                out_q <= wrap_d;
            end
        end
    end

    assign bus.out  = out_q;
    assign bus.done = done_q;
    assign bus.tc   = bus.ce & ~rst & ~bus.load & (state_q == RUN) & at_end;
endmodule

// File: tb/tb_counter_modulo_down.sv
// Self-checking bench for counter_modulo_down (MODULO=7): directed plan then random.
module tb_counter_modulo_down;
    localparam int M = 7;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fails  = 0;

    // Reference model state
    int m_out;
    bit m_halt;
    bit m_done;
    bit m_up;

    counter_modulo_down_if #(.WIDTH(3)) bus();

    counter_modulo_down #(.MODULO(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive, check tc before the edge, advance model, check out/done after.
    task automatic step(input bit r, input bit c, input bit ld, input int d,
                        input bit md, input bit u);
        bit exp_tc;
        int term;
        @(negedge clk);
        rst = r; bus.ce = c; bus.load = ld; bus.din = 3'(d); bus.mode = md;
`ifdef COUNTER_UPDOWN_EN
        bus.up = u;
        m_up = u;
`else
        m_up = 1'b0;
        if (u) m_up = 1'b0;
`endif
        term = m_up ? M - 1 : 0;
        exp_tc = c && !r && !ld && !m_halt && (m_out == term);
        #1;
        chk("tc", int'(bus.tc), int'(exp_tc));
        @(posedge clk);
        if (r) begin
            m_out = M - 1; m_halt = 0; m_done = 0;
        end else if (ld) begin
            m_out = (d > M - 1) ? M - 1 : d; m_halt = 0; m_done = 0;
        end else if (c && !m_halt) begin
            if (m_out != term)   m_out = m_up ? m_out + 1 : m_out - 1;
            else if (md)         begin m_halt = 1; m_done = 1; end
            else                 m_out = m_up ? 0 : M - 1;
        end
        #1;
        chk("out", int'(bus.out), m_out);
        chk("done", int'(bus.done), int'(m_done));
    endtask

    initial begin
        int seq1 [9] = '{5, 4, 3, 2, 1, 0, 6, 5, 4};
        bit md;
        rst = 1'b1; bus.ce = 1'b0; bus.load = 1'b0; bus.din = '0; bus.mode = 1'b0;
`ifdef COUNTER_UPDOWN_EN
        bus.up = 1'b0;
`endif
        m_out = M - 1; m_halt = 0; m_done = 0; m_up = 0;

        // 1: reset then free-running wrap
        step(1, 0, 0, 0, 0, 0);
        chk("reset_out", int'(bus.out), 6);
        chk("reset_done", int'(bus.done), 0);
        for (int i = 0; i < 9; i++) begin
            step(0, 1, 0, 0, 0, 0);
            chk("wrap_seq", int'(bus.out), seq1[i]);
        end
        // 2: load beats ce
        step(0, 1, 1, 3, 0, 0);
        chk("load_no_dec", int'(bus.out), 3);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);
        chk("after_load_wrap", int'(bus.out), 6);
        // 3: clamp
        step(0, 0, 1, 7, 0, 0);
        chk("clamp", int'(bus.out), 6);
        step(0, 0, 1, 5, 0, 0);
        // 4: one-shot, then held in HALT with mode toggles
        step(0, 1, 1, 2, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 0);
        chk("oneshot_done", int'(bus.done), 1);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, i[0], 0);
        chk("halt_hold", int'(bus.out), 0);
        step(0, 1, 1, 4, 0, 0);
        chk("reload_done", int'(bus.done), 0);
        step(0, 1, 0, 0, 0, 0);
        // 5: sparse ce from out=1
        step(0, 0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("sparse_wrap", int'(bus.out), 6);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        // 6: rst over load/ce while halted
        step(0, 1, 1, 0, 1, 0);
        step(0, 1, 0, 0, 1, 0);
        step(1, 1, 1, 2, 1, 0);
        chk("rst_prio_out", int'(bus.out), 6);
        step(0, 1, 0, 0, 0, 0);
`ifdef COUNTER_UPDOWN_EN
        step(0, 0, 1, 5, 0, 0);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        chk("up_wrap", int'(bus.out), 0);
`endif
        // Random
        md = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) md = ~md;
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 11) == 0, int'($urandom_range(0, 7)),
                 md, bit'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
